uart_rx_param: RTL and testbench

Parametrised UART receiver for the serial front end. It oversamples the asynchronous Rx_In line, frames start/data/parity/stop bits with configurable widths and parity mode, and checks each frame. Each frame is delivered through a one-entry valid/ready holding register together with break, parity, framing and overrun flags. RTS flow control is derived from holding-register occupancy.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx_param.sv | 157 +++++++++++++++
 tb/tb_uart_rx_param.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   parity_e    - parity mode encoding (matches the PARITY parameter value)
//   rx_state_e  - receiver FSM states
//   ERR_*       - bit positions inside the 4-bit error vector
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    localparam int ERR_BREAK   = 0;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_FRAME   = 2;
    localparam int ERR_OVERRUN = 3;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for an asynchronous serial line plus a
// registered falling-edge detector.
//   Clk      in   system clock
//   Rst      in   synchronous active-high reset (all flops go to line-idle 1)
//   Rx_In    in   asynchronous serial line, idle high
//   rx_sync  out  synchronised line level
//   rx_fall  out  one-Clk pulse on a synchronised 1->0 transition
module uart_rx_sync (
    input  logic Clk,
    input  logic Rst,
    input  logic Rx_In,
    output logic rx_sync,
    output logic rx_fall
);

    logic s1, s2, s_prev;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            s1     <= Rx_In;
            s2     <= s1;
            s_prev <= s2;
        end
    end

    assign rx_sync = s2;
    assign rx_fall = s_prev & ~s2;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with a one-entry valid/ready
// holding register and break/parity/framing/overrun reporting.
//   Clk        in   system clock
//   Rst        in   synchronous active-high reset
//   Baud_Tick  in   one-Clk pulse at OVERSAMPLE x baud
//   Rx_In      in   asynchronous serial line, idle high
//   Rx_Ready   in   consumer accepts the held frame
//   Rx_Valid   out  holding register contains a frame
//   Rx_Data    out  received data, LSB first on the line
//   Rx_Error   out  [0] break [1] parity [2] framing [3] overrun
//   RTS        out  high while the holding register is empty
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 1,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Baud_Tick,
    input  logic                 Rx_In,
    input  logic                 Rx_Ready,
    output logic                 Rx_Valid,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic [3:0]           Rx_Error,
    output logic                 RTS
);
    import uart_pkg::*;

    localparam int              TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   T_MID     = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]   T_END     = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]      LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]      LAST_STOP = 4'(STOP_BITS - 1);

    rx_state_e              state, nstate;
    logic                   rx_s, rx_fall;
    logic [TW-1:0]          tick;
    logic [3:0]             bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit_q, par_err_q, frm_q, brk_q;

    logic mid_hit, end_hit, start_ok, smp_data, smp_par, smp_stop, frame_done;
    logic par_calc, brk_now, brk_fin, frm_fin;

    uart_rx_sync u_sync (
        .Clk     (Clk),
        .Rst     (Rst),
        .Rx_In   (Rx_In),
        .rx_sync (rx_s),
        .rx_fall (rx_fall)
    );

    // state register
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= nstate;
    end

    // next state; start detection is not gated by Baud_Tick so a one-Clk
    // edge pulse cannot be missed at low tick rates
    always_comb begin
        nstate = state;
        case (state)
            IDLE:             if (rx_fall) nstate = START;
            START:            if (mid_hit) nstate = rx_s ? IDLE : DATA;
            DATA:             if (smp_data && bit_cnt == LAST_DATA)
                                  nstate = (PARITY == 0) ? STOP : uart_pkg::PARITY;
            uart_pkg::PARITY: if (smp_par) nstate = STOP;
            STOP:             if (frame_done) nstate = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE:        if (Baud_Tick && rx_s) nstate = IDLE;
            default:          nstate = IDLE;
        endcase
    end

    // sampling strobes
    always_comb begin
        mid_hit    = Baud_Tick && (tick == T_MID);
        end_hit    = Baud_Tick && (tick == T_END);
        start_ok   = (state == START) && mid_hit && !rx_s;
        smp_data   = (state == DATA) && end_hit;
        smp_par    = (state == uart_pkg::PARITY) && end_hit;
        smp_stop   = (state == STOP) && end_hit;
        frame_done = smp_stop && (bit_cnt == LAST_STOP);
    end

    assign par_calc = (^shreg) ^ rx_s;
    // break candidate evaluated while sampling the first stop bit
    assign brk_now  = (shreg == '0) && ((PARITY == 0) || !par_bit_q) && !rx_s;
    assign brk_fin  = (bit_cnt == 4'd0) ? brk_now : brk_q;
    assign frm_fin  = frm_q || !rx_s;

    // tick counter: cleared on the start edge and again at mid start bit so
    // that every later wrap lands in the middle of a bit
    always_ff @(posedge Clk) begin
        if (Rst)
            tick <= '0;
        else if ((state == IDLE && rx_fall) || start_ok)
            tick <= '0;
        else if (Baud_Tick)
            tick <= (tick == T_END) ? '0 : tick + 1'b1;
    end

    // frame datapath
    always_ff @(posedge Clk) begin
        if (Rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            frm_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else if (start_ok) begin
            bit_cnt   <= '0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            frm_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else if (smp_data) begin
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
            bit_cnt <= (bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
        end else if (smp_par) begin
            par_bit_q <= rx_s;
            par_err_q <= (PARITY == int'(PAR_ODD)) ? !par_calc : par_calc;
        end else if (smp_stop) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (!rx_s)            frm_q <= 1'b1;
            if (bit_cnt == 4'd0)  brk_q <= brk_now;
        end
    end

    // holding register; a completing frame may reload it in the same cycle
    // the held one is accepted
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Rx_Valid <= 1'b0;
            Rx_Data  <= '0;
            Rx_Error <= '0;
        end else if (frame_done) begin
            if (!Rx_Valid || Rx_Ready) begin
                Rx_Valid              <= 1'b1;
                Rx_Data               <= brk_fin ? '0 : shreg;
                Rx_Error[ERR_BREAK]   <= brk_fin;
                Rx_Error[ERR_PARITY]  <= par_err_q;
                Rx_Error[ERR_FRAME]   <= frm_fin;
                Rx_Error[ERR_OVERRUN] <= 1'b0;
            end else begin
                Rx_Error[ERR_OVERRUN] <= 1'b1;
            end
        end else if (Rx_Ready) begin
            Rx_Valid <= 1'b0;
        end
    end

    assign RTS = !Rx_Valid;

endmodule

// File: tb/tb_uart_rx_param.sv
module tb_uart_rx_param;
    import uart_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst, Baud_Tick, Rx_In, Rx_Ready;
    logic       Rx_Valid, RTS;
    logic [7:0] Rx_Data;
    logic [3:0] Rx_Error;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    uart_rx_param #(
        .DATA_BITS (8),
        .PARITY    (1),
        .STOP_BITS (2),
        .OVERSAMPLE(16)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Baud_Tick (Baud_Tick),
        .Rx_In     (Rx_In),
        .Rx_Ready  (Rx_Ready),
        .Rx_Valid  (Rx_Valid),
        .Rx_Data   (Rx_Data),
        .Rx_Error  (Rx_Error),
        .RTS       (RTS)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Drives nbits line bits (start, 8 data LSB first, parity, stop0, stop1),
    // 16 Clk each. Rx_Ready is high only on cycle index ready_at.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] stp,
                              input int nbits, input int ready_at);
        logic [11:0] line;
        int c;
        line = {stp[1], stp[0], p, d, 1'b0};
        c = 0;
        for (int k = 0; k < nbits; k++) begin
            for (int j = 0; j < 16; j++) begin
                Rx_In    = line[k];
                Rx_Ready = (c == ready_at);
                c++;
                step(1);
            end
        end
        Rx_Ready = 1'b0;
        Rx_In    = 1'b1;
    endtask

    task automatic accept();
        Rx_Ready = 1'b1;
        step(1);
        Rx_Ready = 1'b0;
    endtask

    initial begin
        Rst = 1'b1; Baud_Tick = 1'b1; Rx_In = 1'b1; Rx_Ready = 1'b0;
        step(3);
        chk("rst_valid", 16'(Rx_Valid), 16'h0);
        chk("rst_data",  16'(Rx_Data),  16'h0);
        chk("rst_err",   16'(Rx_Error), 16'h0);
        chk("rst_rts",   16'(RTS),      16'h1);
        chk("rst_state", 16'(dut.state), 16'(IDLE));
        Rst = 1'b0;
        step(5);

        // clean frame
        send_frame(8'hA5, 1'b0, 2'b11, 12, -1);
        chk("a5_valid", 16'(Rx_Valid), 16'h1);
        chk("a5_data",  16'(Rx_Data),  16'hA5);
        chk("a5_err",   16'(Rx_Error), 16'h0);
        chk("a5_rts",   16'(RTS),      16'h0);
        step(3);
        chk("a5_hold",  16'(Rx_Data),  16'hA5);
        accept();
        chk("a5_acc_valid", 16'(Rx_Valid), 16'h0);
        chk("a5_acc_rts",   16'(RTS),      16'h1);
        step(4);

        // parity error
        send_frame(8'h3C, 1'b1, 2'b11, 12, -1);
        chk("3c_data", 16'(Rx_Data),  16'h3C);
        chk("3c_err",  16'(Rx_Error), 16'h2);
        accept();
        step(4);

        // second stop bit low -> framing, WAIT_IDLE until line high
        send_frame(8'h5A, 1'b0, 2'b01, 12, -1);
        chk("5a_data",  16'(Rx_Data),  16'h5A);
        chk("5a_err",   16'(Rx_Error), 16'h4);
        chk("5a_wait",  16'(dut.state), 16'(WAIT_IDLE));
        step(4);
        chk("5a_idle",  16'(dut.state), 16'(IDLE));
        accept();
        step(4);

        // break: line low for 40 bit times
        Rx_In = 1'b0;
        step(640);
        chk("brk_valid", 16'(Rx_Valid), 16'h1);
        chk("brk_data",  16'(Rx_Data),  16'h0);
        chk("brk_err",   16'(Rx_Error), 16'h5);
        accept();
        step(100);
        chk("brk_low_novalid", 16'(Rx_Valid), 16'h0);
        Rx_In = 1'b1;
        step(40);
        chk("brk_high_novalid", 16'(Rx_Valid), 16'h0);

        // 5-tick glitch -> false start
        Rx_In = 1'b0;
        step(5);
        Rx_In = 1'b1;
        step(40);
        chk("glitch_novalid", 16'(Rx_Valid), 16'h0);
        chk("glitch_idle",    16'(dut.state), 16'(IDLE));
        send_frame(8'h81, 1'b0, 2'b11, 12, -1);
        chk("81_valid", 16'(Rx_Valid), 16'h1);
        chk("81_data",  16'(Rx_Data),  16'h81);
        chk("81_err",   16'(Rx_Error), 16'h0);
        accept();
        step(4);

        // overrun
        send_frame(8'h11, 1'b0, 2'b11, 12, -1);
        chk("ovr_first", 16'(Rx_Data), 16'h11);
        step(4);
        send_frame(8'h22, 1'b0, 2'b11, 12, -1);
        chk("ovr_valid", 16'(Rx_Valid), 16'h1);
        chk("ovr_data",  16'(Rx_Data),  16'h11);
        chk("ovr_err",   16'(Rx_Error), 16'h8);
        accept();
        chk("ovr_acc_valid", 16'(Rx_Valid), 16'h0);
        step(4);

        // accept on the exact completion cycle of the second frame
        send_frame(8'h11, 1'b0, 2'b11, 12, -1);
        step(4);
        send_frame(8'h22, 1'b0, 2'b11, 12, 186);
        chk("same_valid", 16'(Rx_Valid), 16'h1);
        chk("same_data",  16'(Rx_Data),  16'h22);
        chk("same_err",   16'(Rx_Error), 16'h0);
        accept();
        step(4);

        // reset mid-data loses held frame and aborts current one
        send_frame(8'h33, 1'b0, 2'b11, 12, -1);
        send_frame(8'h55, 1'b0, 2'b11, 4, -1);
        Rst = 1'b1;
        step(1);
        chk("mrst_valid", 16'(Rx_Valid), 16'h0);
        chk("mrst_data",  16'(Rx_Data),  16'h0);
        chk("mrst_err",   16'(Rx_Error), 16'h0);
        chk("mrst_rts",   16'(RTS),      16'h1);
        chk("mrst_state", 16'(dut.state), 16'(IDLE));
        Rst = 1'b0;
        step(20);
        send_frame(8'hF0, 1'b0, 2'b11, 12, -1);
        chk("f0_valid", 16'(Rx_Valid), 16'h1);
        chk("f0_data",  16'(Rx_Data),  16'hF0);
        chk("f0_err",   16'(Rx_Error), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
